tl_sequencer_slave: RTL and testbench
=====================================

# tl_sequencer_slave

Avalon-MM responder peripheral that runs a four-way intersection traffic-light sequence in hardware. The Nios II software writes the phase durations and control bits; the block times the phases and drives the four 3-bit traffic-light outputs. It replaces the current software-timed PIO approach, and its light outputs have the same encoding as the existing tl_* exports. It hangs off the Qsys interconnect as a custom component with a single interrupt.

## Interface

Parameters:
- TICK_CYCLES, 50000000: clk_clk cycles per timing tick (1 s at 50 MHz); minimum value 2.

Ports:
- clk_clk  in  1  system clock
- reset_reset  in  1  asynchronous, active-high reset
- avs_address  in  3  word address
- avs_read  in  1  read strobe
- avs_write  in  1  write strobe
- avs_writedata  in  32  write data
- avs_readdata  out  32  read data, registered, read latency 1
- irq  out  1  level interrupt
- tl_0 .. tl_3  out  3 each  light outputs: bit2 red, bit1 yellow, bit0 green
- countdown  out  8  ticks remaining in the current phase

## Operation

Register map (word addresses; unused bits read 0):
- 0 CTRL (RW, reset 0): bit0 enable, bit1 flash, bit2 irq_en.
- 1 GREEN_T (RW, [7:0], reset 10).
- 2 YELLOW_T (RW, [7:0], reset 3).
- 3 ALLRED_T (RW, [7:0], reset 1).
- 4 STATUS: read gives [2:0] state code and bit8 irq_pending. Writing with bit8=1 clears irq_pending.
- 5 COUNT (RO): current count.
- 6, 7: read 0; writes are ignored.

State machine and outputs (tl_0 and tl_2 are the north-south pair; tl_1 and tl_3 are the east-west pair):
- IDLE (0): all outputs 3'b100.
- ALL_RED_A (1): all outputs red.
- NS_GREEN (2): NS 3'b001, EW 3'b100.
- NS_YELLOW (3): NS 3'b010, EW 3'b100.
- ALL_RED_B (4): all outputs red.
- EW_GREEN (5): EW 3'b001, NS 3'b100.
- EW_YELLOW (6): EW 3'b010, NS 3'b100.
- FLASH (7): all outputs 3'b010 or 3'b000, toggling on every tick. Phase starts at 3'b010.
- Normal cycle: 1→2→3→4→5→6→1.

Transitions:
- flash=1 takes priority from any state and enters FLASH on the next cycle.
- flash=0 while in FLASH returns to IDLE.
- enable=0 (and flash=0) forces IDLE on the next cycle. count and the tick counter are both cleared to 0.
- IDLE with enable=1 enters ALL_RED_A on the next cycle and loads count with ALLRED_T.
- On entry to each phase, count loads the matching duration register. A duration of 0 is loaded as 1.
- On each tick: if count==1, advance to the next state and load its duration. Otherwise count decrements.
- Duration writes affect only later loads, never the count already running.

Tick generator:
- 0..TICK_CYCLES-1 counter, running only when the state is not IDLE.
- Pulses tick for one cycle at the terminal value, then wraps to 0.
- Reset to 0 on every entry to ALL_RED_A from IDLE and on every entry to FLASH.

Interrupt:
- irq_pending is set on every entry to NS_GREEN or EW_GREEN.
- If set and clear happen in the same cycle, set wins.
- irq = irq_pending & irq_en.

## Timing

- Reset values: every tl_* output is 3'b100, countdown 0, avs_readdata 0, irq 0, state IDLE.
- Reads: avs_readdata is valid the cycle after avs_read, from a register sampled in the read cycle. A simultaneous write to the same address returns the old value.
- Writes take effect on the clock edge where avs_write is sampled. The state responds one cycle later.
- tl_* and countdown are registered, decoded from state and count with no combinational path from the Avalon inputs.
- Phase duration is exactly (duration × TICK_CYCLES) cycles, except for the first ALL_RED_A after enable.
- Reset asserted mid-sequence returns everything to reset values immediately (asynchronously). Register contents also return to their defaults.

## Test plan

Use TICK_CYCLES=4 for all scenarios.
- Reset, then read addresses 0-5 → 0, 10, 3, 1, 0, 0. Every tl_* output is 3'b100 and irq=0.
- Write GREEN_T=2, YELLOW_T=1, ALLRED_T=1, CTRL=1 → state sequence 1,2,3,4,5,6,1 with dwell 4, 8, 4, 4, 8, 4 cycles. Outputs match the state table at each phase.
- Set CTRL=5 and run to NS_GREEN → irq=1. Write STATUS bit8 → irq drops the next cycle and rises again at EW_GREEN. Issue the clear in the same cycle as the EW_GREEN entry → irq stays 1.
- Write YELLOW_T=0 → yellow lasts 1 tick (4 cycles). Write GREEN_T mid-green → the current green is unchanged and the next green uses the new value.
- Write CTRL=3 mid-cycle → FLASH. All tl_* read 3'b010 for 4 cycles, then 3'b000, alternating. Write CTRL=1 → IDLE for one cycle, then ALL_RED_A.
- Write CTRL=0 mid-EW_GREEN → IDLE with countdown=0 the next cycle. Assert reset_reset mid-phase → all reset values, and GREEN_T reads back 10.

Source files
------------

// File: rtl/tl_sequencer_slave_if.sv
// -----------------------------------------------------------------------------
// tl_sequencer_slave_if
//   Avalon-MM slave bus bundle for the traffic-light sequencer.
//   Signals:
//     avs_address    3   word address
//     avs_read       1   read strobe
//     avs_write      1   write strobe
//     avs_writedata  32  write data
//     avs_readdata   32  read data (registered by the slave, latency 1)
//   Modports:
//     master  drives address/strobes/writedata, receives readdata
//     slave   receives address/strobes/writedata, drives readdata
// -----------------------------------------------------------------------------
interface tl_sequencer_slave_if;
    logic [2:0]  avs_address;
    logic        avs_read;
    logic        avs_write;
    logic [31:0] avs_writedata;
    logic [31:0] avs_readdata;

    modport master (
        output avs_address,
        output avs_read,
        output avs_write,
        output avs_writedata,
        input  avs_readdata
    );

    modport slave (
        input  avs_address,
        input  avs_read,
        input  avs_write,
        input  avs_writedata,
        output avs_readdata
    );
endinterface

// File: rtl/tl_sequencer_slave.sv
// -----------------------------------------------------------------------------
// tl_sequencer_slave
//   Avalon-MM peripheral that times a four-way intersection light sequence.
//   Software programs phase durations (in ticks of TICK_CYCLES clocks) and
//   control bits; the block walks the phases and drives four light outputs.
//   Ports:
//     clk_clk      system clock
//     reset_reset  asynchronous, active-high reset
//     avs          Avalon-MM slave bundle (address/read/write/writedata/readdata)
//     irq          level interrupt = irq_pending & irq_en
//     tl_0..tl_3   lights {red, yellow, green}; tl_0/tl_2 = NS, tl_1/tl_3 = EW
//     countdown    ticks remaining in the current phase
//   Register map (word address):
//     0 CTRL     [0] enable, [1] flash, [2] irq_en
//     1 GREEN_T  [7:0]
//     2 YELLOW_T [7:0]
//     3 ALLRED_T [7:0]
//     4 STATUS   [2:0] state, [8] irq_pending (write 1 to bit8 clears)
//     5 COUNT    [7:0] current count (read only)
// -----------------------------------------------------------------------------
module tl_sequencer_slave #(
    parameter int unsigned TICK_CYCLES = 50000000
) (
    input  logic                 clk_clk,
    input  logic                 reset_reset,
    tl_sequencer_slave_if.slave  avs,
    output logic                 irq,
    output logic [2:0]           tl_0,
    output logic [2:0]           tl_1,
    output logic [2:0]           tl_2,
    output logic [2:0]           tl_3,
    output logic [7:0]           countdown
);

    localparam int unsigned TW = (TICK_CYCLES > 2) ? $clog2(TICK_CYCLES) : 1;
    localparam logic [TW-1:0] TICK_LAST = TW'(TICK_CYCLES - 1);

    localparam logic [2:0] RED = 3'b100;
    localparam logic [2:0] YEL = 3'b010;
    localparam logic [2:0] GRN = 3'b001;

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        ALL_RED_A = 3'd1,
        NS_GREEN  = 3'd2,
        NS_YELLOW = 3'd3,
        ALL_RED_B = 3'd4,
        EW_GREEN  = 3'd5,
        EW_YELLOW = 3'd6,
        FLASH     = 3'd7
    } state_e;

    // Programmable registers
    logic [2:0]  ctrl_q;
    logic [7:0]  green_q, yellow_q, allred_q;
    logic        irq_pending_q, irq_pending_d;
    logic [31:0] rdata_q, rdata_d;

    // Sequencer state
    state_e        state_q, state_d;
    logic [7:0]    count_q, count_d;
    logic [TW-1:0] tick_q, tick_d;
    logic          flash_q, flash_d;
    logic [11:0]   tl_q, tl_d;       // {tl_0, tl_1, tl_2, tl_3}

    logic          tick_hit;
    logic          green_entry;
    state_e        phase_nxt;
    logic [7:0]    phase_dur;

    logic          unused_wdata_bits;
    assign unused_wdata_bits = ^{avs.avs_writedata[31:9], avs.avs_writedata[7:3]};

    wire wr_en = avs.avs_write;
    wire [2:0] addr = avs.avs_address;

    // ------------------------------------------------------------------
    // Register file, interrupt flag and read-data register
    // ------------------------------------------------------------------
    always_ff @(posedge clk_clk or posedge reset_reset) begin
        if (reset_reset) begin
            ctrl_q        <= '0;
            green_q       <= 8'd10;
            yellow_q      <= 8'd3;
            allred_q      <= 8'd1;
            irq_pending_q <= 1'b0;
            rdata_q       <= '0;
        end else begin
            if (wr_en) begin
                unique case (addr)
                    3'd0:    ctrl_q   <= avs.avs_writedata[2:0];
                    3'd1:    green_q  <= avs.avs_writedata[7:0];
                    3'd2:    yellow_q <= avs.avs_writedata[7:0];
                    3'd3:    allred_q <= avs.avs_writedata[7:0];
                    default: ;
                endcase
            end
            irq_pending_q <= irq_pending_d;
            rdata_q       <= rdata_d;
        end
    end

    // Set on green entry has priority over a software clear in the same cycle.
    always_comb begin
        irq_pending_d = irq_pending_q;
        if (wr_en && (addr == 3'd4) && avs.avs_writedata[8])
            irq_pending_d = 1'b0;
        if (green_entry)
            irq_pending_d = 1'b1;
    end

    // Read mux samples current register values, so a write in the same
    // cycle returns the old contents.
    always_comb begin
        rdata_d = '0;
        if (avs.avs_read) begin
            unique case (addr)
                3'd0:    rdata_d = {29'd0, ctrl_q};
                3'd1:    rdata_d = {24'd0, green_q};
                3'd2:    rdata_d = {24'd0, yellow_q};
                3'd3:    rdata_d = {24'd0, allred_q};
                3'd4:    rdata_d = {23'd0, irq_pending_q, 5'd0, state_q};
                3'd5:    rdata_d = {24'd0, count_q};
                default: rdata_d = '0;
            endcase
        end
    end

    assign avs.avs_readdata = rdata_q;
    assign irq              = irq_pending_q & ctrl_q[2];

    // ------------------------------------------------------------------
    // FSM: state register (outputs registered alongside)
    // ------------------------------------------------------------------
    always_ff @(posedge clk_clk or posedge reset_reset) begin
        if (reset_reset) begin
            state_q <= IDLE;
            count_q <= '0;
            tick_q  <= '0;
            flash_q <= 1'b0;
            tl_q    <= {RED, RED, RED, RED};
        end else begin
            state_q <= state_d;
            count_q <= count_d;
            tick_q  <= tick_d;
            flash_q <= flash_d;
            tl_q    <= tl_d;
        end
    end

    // Successor phase of the normal cycle and its duration (0 loads as 1)
    always_comb begin
        phase_nxt = ALL_RED_A;
        phase_dur = allred_q;
        unique case (state_q)
            ALL_RED_A: begin phase_nxt = NS_GREEN;  phase_dur = green_q;  end
            NS_GREEN:  begin phase_nxt = NS_YELLOW; phase_dur = yellow_q; end
            NS_YELLOW: begin phase_nxt = ALL_RED_B; phase_dur = allred_q; end
            ALL_RED_B: begin phase_nxt = EW_GREEN;  phase_dur = green_q;  end
            EW_GREEN:  begin phase_nxt = EW_YELLOW; phase_dur = yellow_q; end
            default:   begin phase_nxt = ALL_RED_A; phase_dur = allred_q; end
        endcase
        if (phase_dur == 8'd0)
            phase_dur = 8'd1;
    end

    // ------------------------------------------------------------------
    // FSM: next-state logic (state, count, tick counter, flash phase)
    // ------------------------------------------------------------------
    assign tick_hit = (state_q != IDLE) && (tick_q == TICK_LAST);

    always_comb begin
        state_d = state_q;
        count_d = count_q;
        flash_d = flash_q;
        if (state_q == IDLE || tick_hit)
            tick_d = '0;
        else
            tick_d = tick_q + 1'b1;

        if (ctrl_q[1]) begin
            if (state_q != FLASH) begin
                state_d = FLASH;
                count_d = '0;
                tick_d  = '0;
                flash_d = 1'b1;
            end else if (tick_hit) begin
                flash_d = ~flash_q;
            end
        end else if (!ctrl_q[0]) begin
            state_d = IDLE;
            count_d = '0;
            tick_d  = '0;
        end else begin
            unique case (state_q)
                IDLE: begin
                    state_d = ALL_RED_A;
                    count_d = (allred_q == 8'd0) ? 8'd1 : allred_q;
                    tick_d  = '0;
                end
                FLASH: begin
                    state_d = IDLE;
                    count_d = '0;
                    tick_d  = '0;
                end
                default: begin
                    if (tick_hit) begin
                        if (count_q <= 8'd1) begin
                            state_d = phase_nxt;
                            count_d = phase_dur;
                        end else begin
                            count_d = count_q - 8'd1;
                        end
                    end
                end
            endcase
        end
    end

    assign green_entry = (state_d != state_q) &&
                         ((state_d == NS_GREEN) || (state_d == EW_GREEN));

    // ------------------------------------------------------------------
    // FSM: output decode from next state so registered lights line up
    // with the state register
    // ------------------------------------------------------------------
    always_comb begin
        tl_d = {RED, RED, RED, RED};
        unique case (state_d)
            NS_GREEN:  tl_d = {GRN, RED, GRN, RED};
            NS_YELLOW: tl_d = {YEL, RED, YEL, RED};
            EW_GREEN:  tl_d = {RED, GRN, RED, GRN};
            EW_YELLOW: tl_d = {RED, YEL, RED, YEL};
            FLASH:     tl_d = flash_d ? {YEL, YEL, YEL, YEL} : '0;
            default:   tl_d = {RED, RED, RED, RED};
        endcase
    end

    assign tl_0      = tl_q[11:9];
    assign tl_1      = tl_q[8:6];
    assign tl_2      = tl_q[5:3];
    assign tl_3      = tl_q[2:0];
    assign countdown = count_q;

endmodule

// File: tb/tb_tl_sequencer_slave.sv
module tb_tl_sequencer_slave;

    logic       clk_clk;
    logic       reset_reset;
    logic       irq;
    logic [2:0] tl_0, tl_1, tl_2, tl_3;
    logic [7:0] countdown;

    tl_sequencer_slave_if bus();

    tl_sequencer_slave #(.TICK_CYCLES(4)) dut (
        .clk_clk     (clk_clk),
        .reset_reset (reset_reset),
        .avs         (bus),
        .irq         (irq),
        .tl_0        (tl_0),
        .tl_1        (tl_1),
        .tl_2        (tl_2),
        .tl_3        (tl_3),
        .countdown   (countdown)
    );

    initial clk_clk = 1'b0;
    always #5 clk_clk = ~clk_clk;

    int errors = 0;
    int checks = 0;
    int cyc    = 0;

    localparam logic [11:0] ALL_RED  = 12'b100_100_100_100;
    localparam logic [11:0] ALL_YEL  = 12'b010_010_010_010;
    localparam logic [11:0] ALL_OFF  = 12'b000_000_000_000;

    wire [11:0] tl_all = {tl_0, tl_1, tl_2, tl_3};

    function automatic logic [11:0] exp_tl(input logic [2:0] code);
        case (code)
            3'd2:    return 12'b001_100_001_100;
            3'd3:    return 12'b010_100_010_100;
            3'd5:    return 12'b100_001_100_001;
            3'd6:    return 12'b100_010_100_010;
            default: return ALL_RED;
        endcase
    endfunction

    // All bus tasks start and end on a falling edge.
    task automatic wr(input logic [2:0] a, input logic [31:0] d);
        bus.avs_address   = a;
        bus.avs_writedata = d;
        bus.avs_write     = 1'b1;
        @(negedge clk_clk);
        bus.avs_write     = 1'b0;
        cyc++;
    endtask

    task automatic rd(input logic [2:0] a, output logic [31:0] d);
        bus.avs_address = a;
        bus.avs_read    = 1'b1;
        @(negedge clk_clk);
        bus.avs_read    = 1'b0;
        d = bus.avs_readdata;
        cyc++;
    endtask

    task automatic wait_until(input int k);
        while (cyc < k) begin
            @(negedge clk_clk);
            cyc++;
        end
    endtask

    task automatic do_reset;
        bus.avs_read  = 1'b0;
        bus.avs_write = 1'b0;
        reset_reset   = 1'b1;
        @(negedge clk_clk);
        @(negedge clk_clk);
        reset_reset   = 1'b0;
        @(negedge clk_clk);
    endtask

    // Standard small durations, then enable with the given CTRL; cyc=0 after.
    task automatic start_run(input logic [31:0] ctrl, input logic [7:0] yel);
        do_reset();
        wr(3'd1, 32'd2);
        wr(3'd2, {24'd0, yel});
        wr(3'd3, 32'd1);
        wr(3'd0, ctrl);
        cyc = 0;
    endtask

    task automatic test_reset;
        logic [31:0] d;
        logic [31:0] rexp [6];
        rexp = '{32'd0, 32'd10, 32'd3, 32'd1, 32'd0, 32'd0};
        do_reset();
        checks++;
        if (tl_all !== ALL_RED) begin
            errors++; $display("FAIL reset_tl: got %h expected %h", tl_all, ALL_RED);
        end
        checks++;
        if (irq !== 1'b0 || countdown !== 8'd0) begin
            errors++; $display("FAIL reset_irq_count: got irq=%b count=%0d expected 0/0", irq, countdown);
        end
        for (int a = 0; a < 6; a++) begin
            rd(a[2:0], d);
            checks++;
            if (d !== rexp[a]) begin
                errors++; $display("FAIL reset_read[%0d]: got %h expected %h", a, d, rexp[a]);
            end
        end
        // read and write of the same address in one cycle returns old value
        bus.avs_address = 3'd1; bus.avs_writedata = 32'd5;
        bus.avs_read = 1'b1; bus.avs_write = 1'b1;
        @(negedge clk_clk);
        bus.avs_read = 1'b0; bus.avs_write = 1'b0;
        checks++;
        if (bus.avs_readdata !== 32'd10) begin
            errors++; $display("FAIL rw_collision: got %h expected %h", bus.avs_readdata, 32'd10);
        end
        rd(3'd1, d);
        checks++;
        if (d !== 32'd5) begin
            errors++; $display("FAIL green_wr: got %h expected %h", d, 32'd5);
        end
        wr(3'd6, 32'hFFFF_FFFF);
        rd(3'd6, d);
        checks++;
        if (d !== 32'd0) begin
            errors++; $display("FAIL addr6_read: got %h expected 0", d);
        end
        wr(3'd0, 32'hFFFF_FFF8);
        rd(3'd0, d);
        checks++;
        if (d !== 32'd0) begin
            errors++; $display("FAIL ctrl_unused_bits: got %h expected 0", d);
        end
    endtask

    task automatic test_sequence;
        logic [2:0]  code, cur;
        logic [11:0] prev_tl;
        logic        prev_valid;
        int          len, seg;
        int          codes [6];
        int          lens  [6];
        int          ecode [6];
        int          elen  [6];
        ecode = '{1, 2, 3, 4, 5, 6};
        elen  = '{4, 8, 4, 4, 8, 4};
        start_run(32'd1, 8'd1);
        bus.avs_address = 3'd4;
        bus.avs_read    = 1'b1;
        cur = 3'd0; len = 0; seg = 0; prev_valid = 1'b0; prev_tl = '0;
        // readdata shows the state one cycle late; compare against lights
        // captured on the previous falling edge
        for (int i = 0; i < 80 && seg < 6; i++) begin
            @(negedge clk_clk);
            code = bus.avs_readdata[2:0];
            if (prev_valid && code != 3'd0) begin
                checks++;
                if (prev_tl !== exp_tl(code)) begin
                    errors++; $display("FAIL seq_lights st=%0d: got %h expected %h", code, prev_tl, exp_tl(code));
                end
            end
            prev_tl = tl_all; prev_valid = 1'b1;
            if (code != cur) begin
                if (cur != 3'd0) begin
                    codes[seg] = int'(cur); lens[seg] = len; seg++;
                end
                cur = code; len = 1;
            end else begin
                len++;
            end
        end
        bus.avs_read = 1'b0;
        checks++;
        if (seg != 6 || cur != 3'd1) begin
            errors++; $display("FAIL seq_count: got %0d phases then st=%0d expected 6 then 1", seg, cur);
        end else begin
            for (int s = 0; s < 6; s++) begin
                checks++;
                if (codes[s] != ecode[s] || lens[s] != elen[s]) begin
                    errors++;
                    $display("FAIL seq_phase[%0d]: got st=%0d dwell=%0d expected st=%0d dwell=%0d",
                             s, codes[s], lens[s], ecode[s], elen[s]);
                end
            end
        end
        @(negedge clk_clk);
    endtask

    task automatic test_irq;
        int rise;
        start_run(32'd5, 8'd1);
        rise = 0;
        for (int i = 1; i <= 20 && rise == 0; i++) begin
            @(negedge clk_clk);
            cyc++;
            if (irq === 1'b1) rise = i;
        end
        checks++;
        if (rise != 5 || tl_0 !== 3'b001) begin
            errors++; $display("FAIL irq_ns_green: got rise at %0d tl_0=%b expected 5/001", rise, tl_0);
        end
        wr(3'd4, 32'h100);
        checks++;
        if (irq !== 1'b0) begin
            errors++; $display("FAIL irq_clear: got %b expected 0", irq);
        end
        wait_until(20);
        checks++;
        if (irq !== 1'b0 || tl_all !== ALL_RED) begin
            errors++; $display("FAIL irq_before_ew: got irq=%b tl=%h expected 0/%h", irq, tl_all, ALL_RED);
        end
        wr(3'd4, 32'h100);  // clear coincides with EW_GREEN entry
        checks++;
        if (irq !== 1'b1 || tl_1 !== 3'b001) begin
            errors++; $display("FAIL irq_set_wins: got irq=%b tl_1=%b expected 1/001", irq, tl_1);
        end
    endtask

    task automatic test_durations;
        start_run(32'd1, 8'd0);
        wait_until(7);
        wr(3'd1, 32'd1);  // mid NS green
        checks++;
        if (countdown !== 8'd2 || tl_0 !== 3'b001) begin
            errors++; $display("FAIL green_unchanged: got count=%0d tl_0=%b expected 2/001", countdown, tl_0);
        end
        wait_until(12);
        checks++;
        if (tl_0 !== 3'b001) begin
            errors++; $display("FAIL green_end: got %b expected 001", tl_0);
        end
        wait_until(13);
        checks++;
        if (tl_0 !== 3'b010 || countdown !== 8'd1) begin
            errors++; $display("FAIL yellow0_load: got tl_0=%b count=%0d expected 010/1", tl_0, countdown);
        end
        wait_until(16);
        checks++;
        if (tl_0 !== 3'b010) begin
            errors++; $display("FAIL yellow0_hold: got %b expected 010", tl_0);
        end
        wait_until(17);
        checks++;
        if (tl_all !== ALL_RED) begin
            errors++; $display("FAIL yellow0_end: got %h expected %h", tl_all, ALL_RED);
        end
        wait_until(21);
        checks++;
        if (tl_1 !== 3'b001 || countdown !== 8'd1) begin
            errors++; $display("FAIL new_green_load: got tl_1=%b count=%0d expected 001/1", tl_1, countdown);
        end
        wait_until(24);
        checks++;
        if (tl_1 !== 3'b001) begin
            errors++; $display("FAIL new_green_hold: got %b expected 001", tl_1);
        end
        wait_until(25);
        checks++;
        if (tl_1 !== 3'b010) begin
            errors++; $display("FAIL new_green_end: got %b expected 010", tl_1);
        end
    endtask

    task automatic test_flash;
        logic [31:0] d;
        start_run(32'd1, 8'd1);
        wait_until(7);
        wr(3'd0, 32'd3);
        checks++;
        if (tl_0 !== 3'b001) begin
            errors++; $display("FAIL flash_delay: got %b expected 001", tl_0);
        end
        wait_until(9);
        checks++;
        if (tl_all !== ALL_YEL || countdown !== 8'd0) begin
            errors++; $display("FAIL flash_enter: got %h count=%0d expected %h/0", tl_all, countdown, ALL_YEL);
        end
        wait_until(12);
        checks++;
        if (tl_all !== ALL_YEL) begin
            errors++; $display("FAIL flash_on_hold: got %h expected %h", tl_all, ALL_YEL);
        end
        wait_until(13);
        checks++;
        if (tl_all !== ALL_OFF) begin
            errors++; $display("FAIL flash_off: got %h expected %h", tl_all, ALL_OFF);
        end
        wait_until(16);
        checks++;
        if (tl_all !== ALL_OFF) begin
            errors++; $display("FAIL flash_off_hold: got %h expected %h", tl_all, ALL_OFF);
        end
        wait_until(17);
        checks++;
        if (tl_all !== ALL_YEL) begin
            errors++; $display("FAIL flash_on_again: got %h expected %h", tl_all, ALL_YEL);
        end
        wr(3'd0, 32'd1);
        @(negedge clk_clk); cyc++;
        checks++;
        if (tl_all !== ALL_RED || countdown !== 8'd0) begin
            errors++; $display("FAIL flash_exit_idle: got %h count=%0d expected %h/0", tl_all, countdown, ALL_RED);
        end
        rd(3'd4, d);
        checks++;
        if (d[2:0] !== 3'd0 || countdown !== 8'd1) begin
            errors++; $display("FAIL flash_idle_one: got st=%0d count=%0d expected 0/1", d[2:0], countdown);
        end
        rd(3'd4, d);
        checks++;
        if (d[2:0] !== 3'd1) begin
            errors++; $display("FAIL flash_then_allred: got %0d expected 1", d[2:0]);
        end
    endtask

    task automatic test_disable_reset;
        logic [31:0] d;
        start_run(32'd5, 8'd1);
        wait_until(23);
        wr(3'd0, 32'd4);
        checks++;
        if (tl_1 !== 3'b001 || countdown !== 8'd2 || irq !== 1'b1) begin
            errors++; $display("FAIL disable_delay: got tl_1=%b count=%0d irq=%b expected 001/2/1", tl_1, countdown, irq);
        end
        @(negedge clk_clk); cyc++;
        checks++;
        if (tl_all !== ALL_RED || countdown !== 8'd0) begin
            errors++; $display("FAIL disable_idle: got %h count=%0d expected %h/0", tl_all, countdown, ALL_RED);
        end
        wait_until(28);
        checks++;
        if (countdown !== 8'd0 || tl_all !== ALL_RED) begin
            errors++; $display("FAIL idle_hold: got %h count=%0d expected %h/0", tl_all, countdown, ALL_RED);
        end
        wr(3'd0, 32'd5);
        wait_until(33);
        checks++;
        if (tl_0 !== 3'b100 || countdown !== 8'd1) begin
            errors++; $display("FAIL reenable_allred: got tl_0=%b count=%0d expected 100/1", tl_0, countdown);
        end
        wait_until(34);
        checks++;
        if (tl_0 !== 3'b001 || countdown !== 8'd2) begin
            errors++; $display("FAIL reenable_green: got tl_0=%b count=%0d expected 001/2", tl_0, countdown);
        end
        wr(3'd1, 32'd7);
        reset_reset = 1'b1;
        #1;
        checks++;
        if (tl_all !== ALL_RED || countdown !== 8'd0 || irq !== 1'b0 || bus.avs_readdata !== 32'd0) begin
            errors++; $display("FAIL async_reset: got tl=%h count=%0d irq=%b rd=%h expected %h/0/0/0",
                               tl_all, countdown, irq, bus.avs_readdata, ALL_RED);
        end
        @(negedge clk_clk);
        reset_reset = 1'b0;
        rd(3'd1, d);
        checks++;
        if (d !== 32'd10) begin
            errors++; $display("FAIL reset_green_default: got %0d expected 10", d);
        end
        rd(3'd0, d);
        checks++;
        if (d !== 32'd0) begin
            errors++; $display("FAIL reset_ctrl_default: got %0d expected 0", d);
        end
    endtask

    initial begin
        reset_reset       = 1'b1;
        bus.avs_address   = '0;
        bus.avs_read      = 1'b0;
        bus.avs_write     = 1'b0;
        bus.avs_writedata = '0;
        @(negedge clk_clk);
        test_reset();
        test_sequence();
        test_irq();
        test_durations();
        test_flash();
        test_disable_reset();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
